// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage pipeline (load-use, taken branch, slow dmem).
// Optional perf counters when HAZARD_PERF_EN is defined.
//
// Parameters:
//   MEM_TIMEOUT  number of frozen MEM_WAIT cycles before mem_timeout latches
//   CNT_W        perf counter width (HAZARD_PERF_EN only)
//
// Ports:
//   clk, reset                          clock, sync active-high reset
//   if_id_rs1/rs2, if_id_uses_rs1/rs2   source regs of the ID instruction
//   id_ex_rd, id_ex_mem_read            destination / load flag of the EX instruction
//   ex_branch_taken                     taken branch resolved in EX
//   dmem_req, dmem_ready                data-memory handshake from MEM
//   pc_write .. mem_wb_flush            pipeline register enables and flushes
//   mem_timeout                         sticky dmem timeout error
//   stall_cycles, loaduse_count,
//   flush_count                         perf counters (HAZARD_PERF_EN only)
module hazard_control_unit #(
   parameter int unsigned MEM_TIMEOUT = 255
`ifdef HAZARD_PERF_EN
   ,
   parameter int unsigned CNT_W = 32
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] if_id_rs1,
   input  logic [4:0] if_id_rs2,
   input  logic       if_id_uses_rs1,
   input  logic       if_id_uses_rs2,
   input  logic [4:0] id_ex_rd,
   input  logic       id_ex_mem_read,
   input  logic       ex_branch_taken,
   input  logic       dmem_req,
   input  logic       dmem_ready,
`ifdef HAZARD_PERF_EN
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] loaduse_count,
   output logic [CNT_W-1:0] flush_count,
`endif
   output logic       pc_write,
   output logic       if_id_write,
   output logic       if_id_flush,
   output logic       id_ex_write,
   output logic       id_ex_flush,
   output logic       ex_mem_write,
   output logic       mem_wb_flush,
   output logic       mem_timeout
);

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_e;

   localparam logic [15:0] TO_LIM = 16'(MEM_TIMEOUT);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        to_q, to_d;

   logic lu_hit;
   logic freeze;
   logic br_flush;
   logic lu_bubble;

   assign lu_hit = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                   ((if_id_uses_rs1 && (if_id_rs1 == id_ex_rd)) ||
                    (if_id_uses_rs2 && (if_id_rs2 == id_ex_rd)));

   // In MEM_WAIT the access is already in flight, so only ready matters.
   assign freeze = !reset &&
                   ((state_q == RUN) ? (dmem_req && !dmem_ready)
                                     : !dmem_ready);

   // The three actions are mutually exclusive by construction.
   assign br_flush  = !reset && !freeze && ex_branch_taken;
   assign lu_bubble = !reset && !freeze && !ex_branch_taken && lu_hit;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= 16'd0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      if (freeze) begin
         state_d = MEM_WAIT;
         if (state_q == RUN) begin
            cnt_d = 16'd1;
         end else if (cnt_q < TO_LIM) begin
            cnt_d = cnt_q + 16'd1;
         end
         if (cnt_d >= TO_LIM) begin
            to_d = 1'b1;
         end
      end else begin
         state_d = RUN;
         cnt_d   = 16'd0;
      end
   end

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_write  = 1'b1;
      id_ex_flush  = 1'b0;
      ex_mem_write = 1'b1;
      mem_wb_flush = 1'b0;
      unique case (1'b1)
         freeze: begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
         end
         br_flush: begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end
         lu_bubble: begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign mem_timeout = to_q && !reset;

`ifdef HAZARD_PERF_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] stall_q, lu_q, fl_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
         lu_q    <= '0;
         fl_q    <= '0;
      end else begin
         if ((freeze || lu_bubble) && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + 1'b1;
         end
         if (lu_bubble && (lu_q != CNT_MAX)) begin
            lu_q <= lu_q + 1'b1;
         end
         if (br_flush && (fl_q != CNT_MAX)) begin
            fl_q <= fl_q + 1'b1;
         end
      end
   end

   assign stall_cycles  = stall_q;
   assign loaduse_count = lu_q;
   assign flush_count   = fl_q;
`endif

endmodule
